alu_responder: RTL and testbench
================================

# alu_responder

Handshaked, registered front end for the combinational 32-bit ALU. Accepts operation requests (a, b, control, tag) on a valid/ready interface, evaluates them through one instance of the existing `alu`, and returns result plus flags in order on a response valid/ready interface through a 2-entry output buffer. It is the responding end of the operand/control stream that the ALU bench drives today, and it is the unit the multicycle CPU datapath and the hardware self-test sequencer talk to.

## Interface
- N, 32, datapath width; only 32 is supported.
- TAG_W, 4, width of the opaque request tag returned with each response.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; equals (count < 2), registered-state only, with no combinational path from rsp_ready.
- req_a, req_b  in  N  operands.
- req_control  in  alu_control_t  operation select.
- req_tag  in  TAG_W  returned unchanged on the response.
- rsp_valid  out  1  buffer head holds a response (count != 0).
- rsp_ready  in  1  consumer takes the head.
- rsp_result  out  N  ALU result.
- rsp_overflow, rsp_zero, rsp_equal  out  1 each  ALU flags, with the same meaning as on `alu`.
- rsp_illegal  out  1  control was not a defined alu_control_t value.
- rsp_tag  out  TAG_W  tag of the request.

## Operation
- Accept on a cycle with req_valid && req_ready. Compute through `alu` in the same cycle, and write {result, flags, illegal, tag} into the buffer tail at the edge.
- Pop on a cycle with rsp_valid && rsp_ready. The head advances at the edge.
- Buffer is a 2-entry circular FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
  - States: EMPTY (0), ONE (1), FULL (2).
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together in ONE: count stays 1, pointers both advance.
  - Push and pop in EMPTY: push only, because the response is not yet visible.
  - FULL: req_ready=0, so no push.
- Pointers wrap 1→0.
- Responses leave in acceptance order. Stored contents never change while held, even if request inputs or rsp_ready toggle.
- Illegal control: rsp_result=0, overflow=0, rsp_illegal=1. zero and equal are still computed from the result of 0 and from a==b.
- req_* inputs are ignored when req_valid=0. rsp_* data is don't-care when rsp_valid=0, but must hold its last value, not X.

## Timing
- Latency: a request accepted at edge k has rsp_valid=1 in the cycle after edge k.
- Throughput: 1 op/cycle sustained when rsp_ready=1 continuously (steady-state count=1).
- Backpressure: with rsp_ready=0, two requests are accepted, then req_ready drops the cycle after the second accept.
- Reset values: req_ready=1, rsp_valid=0, count=0, wr_ptr=rd_ptr=0, rsp_result=0, all rsp flags=0, rsp_tag=0.
- rst asserted mid-operation flushes all buffered responses at that edge. Requests presented during the rst cycle are not accepted, and rst overrides simultaneous push/pop.

## Configuration
- ALU_RESPONDER_STATS_EN defined:
  - Adds outputs stat_ops (32 bits, increments on every accept), stat_overflows (16 bits, increments on accepts whose ALU overflow=1) and stat_illegal (16 bits).
  - All counters reset to 0 and wrap silently.
  - Counters update at the accept edge, not the pop edge.
- Not defined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- alu_types package holds:
  - alu_control_t;
  - a function alu_control_legal(alu_control_t) returning 1 for defined encodings;
  - a packed struct alu_rsp_t {result, overflow, zero, equal, illegal, tag}, with the tag width taken from TAG_W via a package parameter of 4.
- The buffer entry type is alu_rsp_t.
- Sub-modules:
  - the existing `alu`, instantiated once;
  - `alu_rsp_fifo2`, the 2-entry buffer with push/pop/count. This is the natural split, and it is tested standalone for full/empty and wrap-around.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001, tag=3, rsp_ready=1 → next cycle rsp_valid=1, result=0x80000000, overflow=1, zero=0, tag=3.
- SUB a=b=0x12345678 → result=0, zero=1, equal=1, overflow=0.
- rsp_ready=0, issue 3 back-to-back requests with tags 1, 2, 3 → tags 1 and 2 accepted, req_ready=0 from the third cycle, tag 3 held. Raise rsp_ready → responses emerge in order 1, 2, 3.
- Streaming 20 random ops with rsp_ready=1 → one response per cycle, each matching `alu_behavioural`. With STATS_EN, stat_ops=20.
- Illegal control 4'hF with a=5, b=5 → result=0, illegal=1, equal=1, overflow=0.
- Two responses buffered, rst pulsed for one cycle → rsp_valid=0 and req_ready=1 the next cycle. The next accepted request is the first response out.

Source files
------------

// File: rtl/alu_types.sv
// alu_types: shared types for the ALU and its handshaked responder.
//   alu_control_t      4-bit operation select (AND, OR, ADD, SUB, SLT, NOR)
//   alu_control_legal  1 for defined encodings, 0 otherwise
//   alu_rsp_t          one response / buffer entry
//   fifo_state_t       occupancy of the 2-entry response buffer
package alu_types;

    localparam int TAG_W = 4;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_control_t;

    typedef struct packed {
        logic [31:0]      result;
        logic             overflow;
        logic             zero;
        logic             equal;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    function automatic logic alu_control_legal(alu_control_t c);
        case (c)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_responder_if.sv
// alu_responder_if: request/response handshake bundle.
//   req_*  : valid/ready request channel (a, b, control, tag)
//   rsp_*  : valid/ready response channel (result, flags, illegal, tag)
// Modports: master drives requests and consumes responses; slave is the
// responder.
interface alu_responder_if
    import alu_types::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     req_a;
    logic [N-1:0]     req_b;
    alu_control_t     req_control;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_result;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic             rsp_equal;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_control, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
               rsp_equal, rsp_illegal, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_control, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
               rsp_equal, rsp_illegal, rsp_tag
    );
endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit ALU.
//   a, b      operands
//   control   operation select
//   result    operation result (0 for undefined control)
//   overflow  signed overflow of ADD/SUB, 0 otherwise
//   zero      result == 0
//   equal     a == b
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = a + b;
                overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                result   = a - b;
                overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);
endmodule

// File: rtl/alu_rsp_fifo2.sv
// alu_rsp_fifo2: 2-entry circular response buffer.
//   clk, rst  clock, synchronous active-high reset
//   push, din write din at the tail (ignored when FULL)
//   pop       advance the head (ignored when EMPTY)
//   dout      head entry; when EMPTY it keeps showing the last popped entry
//   count     occupancy 0..2
module alu_rsp_fifo2
    import alu_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  alu_rsp_t    din,
    output alu_rsp_t    dout,
    output logic [1:0]  count
);
    fifo_state_t state, state_nxt;
    alu_rsp_t    mem [2];
    logic        wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign do_push = push && (state != FULL);
    assign do_pop  = pop  && (state != EMPTY);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (do_push) state_nxt = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_nxt = FULL;
                else if (do_pop && !do_push) state_nxt = EMPTY;
            end
            FULL:    if (do_pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
        end
    end

    // When empty the entry just behind the head is the last one popped
    // (or zero after reset), so the response data holds steady.
    assign dout  = (state == EMPTY) ? mem[~rd_ptr] : mem[rd_ptr];
    assign count = state;
endmodule

// File: rtl/alu_responder.sv
// alu_responder: handshaked, registered front end for the 32-bit ALU.
//   clk, rst  clock, synchronous active-high reset
//   bus       alu_responder_if slave: request in, response out
//   stat_ops, stat_overflows, stat_illegal
//             accept counters, present only with ALU_RESPONDER_STATS_EN
// Requests are evaluated by the ALU in the accept cycle and stored in a
// 2-entry buffer; responses leave in acceptance order.
module alu_responder
    import alu_types::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_responder_if.slave bus
`ifdef ALU_RESPONDER_STATS_EN
    ,
    output logic [31:0]    stat_ops,
    output logic [15:0]    stat_overflows,
    output logic [15:0]    stat_illegal
`endif
);
    logic [N-1:0] alu_result;
    logic         alu_overflow, alu_zero, alu_equal;
    logic         legal, accept, pop;
    logic [1:0]   count;
    alu_rsp_t     rsp_in, rsp_head;

    alu #(.N(N)) u_alu (
        .a        (bus.req_a),
        .b        (bus.req_b),
        .control  (bus.req_control),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    assign legal = alu_control_legal(bus.req_control);

    always_comb begin
        rsp_in          = '0;
        rsp_in.result   = alu_result;
        rsp_in.overflow = alu_overflow;
        rsp_in.zero     = alu_zero;
        rsp_in.equal    = alu_equal;
        rsp_in.illegal  = ~legal;
        rsp_in.tag      = bus.req_tag;
    end

    // req_ready depends only on stored occupancy, never on rsp_ready.
    assign bus.req_ready = (count < 2'd2);
    assign bus.rsp_valid = (count != 2'd0);
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    alu_rsp_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (rsp_in),
        .dout  (rsp_head),
        .count (count)
    );

    assign bus.rsp_result   = rsp_head.result;
    assign bus.rsp_overflow = rsp_head.overflow;
    assign bus.rsp_zero     = rsp_head.zero;
    assign bus.rsp_equal    = rsp_head.equal;
    assign bus.rsp_illegal  = rsp_head.illegal;
    assign bus.rsp_tag      = rsp_head.tag;

`ifdef ALU_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops       <= '0;
            stat_overflows <= '0;
            stat_illegal   <= '0;
        end else if (accept) begin
            stat_ops <= stat_ops + 32'd1;
            if (alu_overflow) stat_overflows <= stat_overflows + 16'd1;
            if (!legal)       stat_illegal   <= stat_illegal + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: directed self-checking bench for alu_responder.
// Inputs change on the falling edge, outputs are sampled on the falling
// edge, so each check sees the state left by the preceding rising edge.
module tb_alu_responder;
    import alu_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_responder_if #(.N(32), .TAG_W(4)) bus ();

`ifdef ALU_RESPONDER_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_overflows, stat_illegal;
`endif

    alu_responder #(.N(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_RESPONDER_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_overflows (stat_overflows),
        .stat_illegal   (stat_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctl, input logic [3:0] tag);
        bus.req_valid   = 1'b1;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_control = alu_control_t'(ctl);
        bus.req_tag     = tag;
    endtask

    // Directed stream: control, a, b, result, overflow, zero
    logic [3:0]  s_ctl [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [31:0] s_a   [6] = '{32'hFF00FF00, 32'hFF00FF00, 32'h00000005,
                               32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] s_b   [6] = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'hFFFFFFFB,
                               32'h00000001, 32'h00000001, 32'h00000000};
    logic [31:0] s_res [6] = '{32'h0F000F00, 32'hFF0FFF0F, 32'h00000000,
                               32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    logic        s_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        s_zer [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_control = ALU_AND;
        bus.req_tag     = '0;
        bus.rsp_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_result",    64'(bus.rsp_result), 64'd0);
        chk("rst_flags",     64'({bus.rsp_overflow, bus.rsp_zero, bus.rsp_equal, bus.rsp_illegal}), 64'd0);
        chk("rst_tag",       64'(bus.rsp_tag), 64'd0);

        // ADD overflow
        bus.rsp_ready = 1'b1;
        drive(32'h7FFFFFFF, 32'h00000001, 4'b0010, 4'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("add_valid", 64'(bus.rsp_valid), 64'd1);
        chk("add_result", 64'(bus.rsp_result), 64'h80000000);
        chk("add_ovf", 64'(bus.rsp_overflow), 64'd1);
        chk("add_zero", 64'(bus.rsp_zero), 64'd0);
        chk("add_tag", 64'(bus.rsp_tag), 64'd3);
        @(negedge clk);
        chk("add_drained", 64'(bus.rsp_valid), 64'd0);
        chk("hold_result", 64'(bus.rsp_result), 64'h80000000);

        // SUB equal operands
        drive(32'h12345678, 32'h12345678, 4'b0110, 4'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("sub_result", 64'(bus.rsp_result), 64'd0);
        chk("sub_flags", 64'({bus.rsp_overflow, bus.rsp_zero, bus.rsp_equal, bus.rsp_illegal}), 64'b0110);

        // Illegal control
        @(negedge clk);
        drive(32'd5, 32'd5, 4'hF, 4'd5);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("ill_valid", 64'(bus.rsp_valid), 64'd1);
        chk("ill_result", 64'(bus.rsp_result), 64'd0);
        chk("ill_flags", 64'({bus.rsp_overflow, bus.rsp_zero, bus.rsp_equal, bus.rsp_illegal}), 64'b0111);
        chk("ill_tag", 64'(bus.rsp_tag), 64'd5);
        @(negedge clk);

        // Backpressure: three back-to-back requests, consumer stalled
        bus.rsp_ready = 1'b0;
        drive(32'd1, 32'd1, 4'b0010, 4'd1);
        @(negedge clk);
        chk("bp_ready1", 64'(bus.req_ready), 64'd1);
        drive(32'd2, 32'd2, 4'b0010, 4'd2);
        @(negedge clk);
        chk("bp_ready_full", 64'(bus.req_ready), 64'd0);
        drive(32'd3, 32'd3, 4'b0010, 4'd3);
        @(negedge clk);
        chk("bp_held_ready", 64'(bus.req_ready), 64'd0);
        chk("bp_head_tag1", 64'(bus.rsp_tag), 64'd1);
        chk("bp_head_res1", 64'(bus.rsp_result), 64'd2);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_tag2", 64'(bus.rsp_tag), 64'd2);
        chk("bp_head_res2", 64'(bus.rsp_result), 64'd4);
        chk("bp_ready_again", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_head_tag3", 64'(bus.rsp_tag), 64'd3);
        chk("bp_head_res3", 64'(bus.rsp_result), 64'd6);
        chk("bp_valid3", 64'(bus.rsp_valid), 64'd1);
        @(negedge clk);
        chk("bp_drained", 64'(bus.rsp_valid), 64'd0);

        // Streaming: one response per cycle with rsp_ready held high
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                chk("st_valid", 64'(bus.rsp_valid), 64'd1);
                chk("st_result", 64'(bus.rsp_result), 64'(s_res[i-1]));
                chk("st_ovf", 64'(bus.rsp_overflow), 64'(s_ovf[i-1]));
                chk("st_zero", 64'(bus.rsp_zero), 64'(s_zer[i-1]));
                chk("st_tag", 64'(bus.rsp_tag), 64'(i-1));
                chk("st_ready", 64'(bus.req_ready), 64'd1);
            end
            if (i < 6) drive(s_a[i], s_b[i], s_ctl[i], 4'(i));
            else       bus.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("st_drained", 64'(bus.rsp_valid), 64'd0);

`ifdef ALU_RESPONDER_STATS_EN
        // 3 single ops + 3 backpressure + 6 streamed; overflows: ADD and SUB
        chk("stat_ops", 64'(stat_ops), 64'd12);
        chk("stat_ovf", 64'(stat_overflows), 64'd2);
        chk("stat_ill", 64'(stat_illegal), 64'd1);
`endif

        // Reset flush with two responses buffered
        bus.rsp_ready = 1'b0;
        drive(32'd7, 32'd0, 4'b0001, 4'd7);
        @(negedge clk);
        drive(32'd8, 32'd0, 4'b0001, 4'd8);
        @(negedge clk);
        chk("fl_full", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        drive(32'd9, 32'd0, 4'b0001, 4'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("fl_valid", 64'(bus.rsp_valid), 64'd0);
        chk("fl_ready", 64'(bus.req_ready), 64'd1);
        drive(32'd10, 32'd0, 4'b0001, 4'd10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("fl_first_valid", 64'(bus.rsp_valid), 64'd1);
        chk("fl_first_tag", 64'(bus.rsp_tag), 64'd10);
        chk("fl_first_res", 64'(bus.rsp_result), 64'd10);
`ifdef ALU_RESPONDER_STATS_EN
        chk("fl_stat_ops", 64'(stat_ops), 64'd1);
`endif
        @(negedge clk);
        chk("fl_drained", 64'(bus.rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
